// File: rtl/pipelined_expr_pkg.sv
// Shared constants for the pipelined f = ((a+b) op (c-d)) * d unit:
// operation modes and width helpers derived from the operand width N.
package pipelined_expr_pkg;

    localparam logic [1:0] MODE_ADDSUB = 2'd0;
    localparam logic [1:0] MODE_SUBSUB = 2'd1;
    localparam logic [1:0] MODE_NOMUL  = 2'd2;
    localparam logic [1:0] MODE_X1MUL  = 2'd3;

    localparam int DEFAULT_N = 10;

    function automatic int x1_w(input int n);
        return n + 1;
    endfunction

    function automatic int x3_w(input int n);
        return n + 3;
    endfunction

    function automatic int p_w(input int n);
        return 2 * n + 4;
    endfunction

endpackage

// File: rtl/pipelined_expr_unit_stage_ctl.sv
// One pipeline slot: a valid bit plus the advance/enable decision used by
// the datapath registers of that slot.
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic load,
    input  logic next_advance,
    output logic valid,
    output logic advance,
    output logic enable
);

    // A slot can take new contents when it is empty or its occupant moves on.
    assign advance = !valid || next_advance;
    assign enable  = advance && load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (advance) begin
            valid <= load;
        end
    end

endmodule

// File: rtl/pipelined_expr_unit.sv
// Three-stage valid/ready pipeline computing f = ((a+b) op (c-d)) * d with
// per-transaction mode, optional output saturation, flush and occupancy.
module pipelined_expr_unit
    import pipelined_expr_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int OUT_W = 2 * N + 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode,
    input  logic [N-1:0]            a,
    input  logic [N-1:0]            b,
    input  logic [N-1:0]            c,
    input  logic [N-1:0]            d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] f,
    output logic                    ovf,
    output logic [1:0]              occupancy
);

    localparam int X1_W = x1_w(N);
    localparam int X3_W = x3_w(N);
    localparam int P_W  = p_w(N);

    localparam logic signed [P_W-1:0] SAT_MAX = {{(P_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] SAT_MIN = ~SAT_MAX;

    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic en1, en2, en3;
    logic in_fire;

    assign in_ready = !flush && adv1;
    assign in_fire  = in_valid && in_ready;

    pipe_stage_ctl u_s1 (.clk(clk), .rst_n(rst_n), .flush(flush), .load(in_fire),
                         .next_advance(adv2), .valid(v1), .advance(adv1), .enable(en1));
    pipe_stage_ctl u_s2 (.clk(clk), .rst_n(rst_n), .flush(flush), .load(v1),
                         .next_advance(adv3), .valid(v2), .advance(adv2), .enable(en2));
    pipe_stage_ctl u_s3 (.clk(clk), .rst_n(rst_n), .flush(flush), .load(v2),
                         .next_advance(out_ready), .valid(v3), .advance(adv3), .enable(en3));

    assign out_valid = v3;
    assign occupancy = 2'(v1) + 2'(v2) + 2'(v3);

    logic        [X1_W-1:0] x1;
    logic signed [X1_W-1:0] x2;
    logic        [N-1:0]    d1, d2;
    logic        [1:0]      m1, m2;
    logic signed [X3_W-1:0] x3, x3_next;
    logic signed [P_W-1:0]  p;
    logic        [OUT_W-1:0] f_next;
    logic                   ovf_next;

    always_comb begin
        x3_next = '0;
        case (m1)
            MODE_ADDSUB, MODE_NOMUL: x3_next = $signed({2'b00, x1}) + X3_W'(x2);
            MODE_SUBSUB:             x3_next = $signed({2'b00, x1}) - X3_W'(x2);
            MODE_X1MUL:              x3_next = $signed({2'b00, x1});
            default:                 x3_next = '0;
        endcase
    end

    // Clamp only when the output is narrower than the full-precision product.
    always_comb begin
        p        = (m2 == MODE_NOMUL) ? P_W'(x3) : P_W'(x3) * $signed(P_W'({1'b0, d2}));
        f_next   = p[OUT_W-1:0];
        ovf_next = 1'b0;
        if (OUT_W < P_W) begin
            if (p > SAT_MAX) begin
                f_next   = SAT_MAX[OUT_W-1:0];
                ovf_next = 1'b1;
            end else if (p < SAT_MIN) begin
                f_next   = SAT_MIN[OUT_W-1:0];
                ovf_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1  <= '0;
            x2  <= '0;
            d1  <= '0;
            m1  <= '0;
            x3  <= '0;
            d2  <= '0;
            m2  <= '0;
            f   <= '0;
            ovf <= 1'b0;
        end else begin
            if (en1) begin
                x1 <= {1'b0, a} + {1'b0, b};
                x2 <= $signed({1'b0, c}) - $signed({1'b0, d});
                d1 <= d;
                m1 <= mode;
            end
            if (en2) begin
                x3 <= x3_next;
                d2 <= d1;
                m2 <= m1;
            end
            if (en3) begin
                f   <= f_next;
                ovf <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_expr_unit.sv
// Directed bench for pipelined_expr_unit: full-width and 12-bit saturating
// instances, scoreboard queues popped by output monitors.
module tb_pipelined_expr_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // full-width instance
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [1:0]         mode = '0;
    logic [9:0]         a = '0, b = '0, c = '0, d = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [23:0] f;
    logic               ovf;
    logic [1:0]         occupancy;

    // 12-bit saturating instance
    logic               s_flush = 1'b0;
    logic               s_in_valid = 1'b0;
    logic               s_in_ready;
    logic [1:0]         s_mode = '0;
    logic [9:0]         s_a = '0, s_b = '0, s_c = '0, s_d = '0;
    logic               s_out_valid;
    logic               s_out_ready = 1'b1;
    logic signed [11:0] s_f;
    logic               s_ovf;
    logic [1:0]         s_occupancy;

    pipelined_expr_unit #(.N(10), .OUT_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .a(a), .b(b), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .ovf(ovf), .occupancy(occupancy)
    );

    pipelined_expr_unit #(.N(10), .OUT_W(12)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .mode(s_mode), .a(s_a), .b(s_b), .c(s_c), .d(s_d), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .f(s_f), .ovf(s_ovf), .occupancy(s_occupancy)
    );

    logic [24:0] exp_q[$];
    logic [12:0] exp12_q[$];

    // Output monitor, full-width instance: pops on transfer, checks stalls hold.
    logic [24:0] held;
    bit          stall_seen = 1'b0;
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            stall_seen = 1'b0;
        end else begin
            if (stall_seen && out_valid) begin
                checks++;
                if ({ovf, f} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h required %h", {ovf, f}, held);
                end
            end
            if (occupancy == 2'd3 && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL in_ready_full got %b required 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out got f=%0d ovf=%b required no output", f, ovf);
                end else begin
                    logic [24:0] e;
                    e = exp_q.pop_front();
                    if ({ovf, f} !== e) begin
                        errors++;
                        $display("FAIL result got f=%0d ovf=%b required f=%0d ovf=%b",
                                 f, ovf, $signed(e[23:0]), e[24]);
                    end
                end
            end
            stall_seen = out_valid && !out_ready;
            held = {ovf, f};
        end
    end

    always @(negedge clk) begin
        if (rst_n && s_out_valid && s_out_ready) begin
            checks++;
            if (exp12_q.size() == 0) begin
                errors++;
                $display("FAIL sat_unexpected got f=%0d required no output", s_f);
            end else begin
                logic [12:0] e;
                e = exp12_q.pop_front();
                if ({s_ovf, s_f} !== e) begin
                    errors++;
                    $display("FAIL sat_result got f=%0d ovf=%b required f=%0d ovf=%b",
                             s_f, s_ovf, $signed(e[11:0]), e[12]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] m, input int va, input int vb, input int vc,
                         input int vd, input int ef, input logic eo);
        int n = 0;
        mode = m; a = va[9:0]; b = vb[9:0]; c = vc[9:0]; d = vd[9:0];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 required 1");
        end else begin
            exp_q.push_back({eo, 24'(ef)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_sat(input logic [1:0] m, input int va, input int vb, input int vc,
                             input int vd, input int ef, input logic eo);
        int n = 0;
        s_mode = m; s_a = va[9:0]; s_b = vb[9:0]; s_c = vc[9:0]; s_d = vd[9:0];
        s_in_valid = 1'b1;
        @(negedge clk);
        while (!s_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_in_ready) begin
            checks++;
            errors++;
            $display("FAIL sat_accept_timeout got in_ready=0 required 1");
        end else begin
            exp12_q.push_back({eo, 12'(ef)});
        end
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
    endtask

    // Called right after a handshake edge (+1) into an empty pipeline.
    task automatic check_latency(input string name);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 32'(lat), 32'd3);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp12_q.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size() + exp12_q.size()), 32'd0);
    endtask

    // Stream table: mode, a, b, c, d, expected f (hand-computed).
    int st_m[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int st_a[8]  = '{1, 10, 100, 7, 1023, 0, 0, 512};
    int st_b[8]  = '{2, 20, 200, 8, 1023, 0, 0, 511};
    int st_c[8]  = '{3, 5, 50, 0, 1023, 0, 0, 9};
    int st_d[8]  = '{4, 9, 70, 3, 1023, 1023, 1023, 2};
    int st_f[8]  = '{8, 306, 280, 45, 2093058, 1046529, -1023, 2046};
    bit stream_done;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_f", 32'(f), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(2'd0, 5, 3, 7, 2, 26, 1'b0);
        check_latency("latency_first");
        wait_drain();
        drive(2'd1, 5, 3, 7, 2, 6, 1'b0);
        drive(2'd2, 5, 3, 7, 2, 13, 1'b0);
        drive(2'd3, 5, 3, 7, 2, 16, 1'b0);
        drive(2'd0, 0, 0, 0, 1023, -1046529, 1'b0);
        wait_drain();

        drive_sat(2'd2, 1023, 1023, 1023, 0, 2047, 1'b1);
        drive_sat(2'd1, 0, 0, 1023, 1, -1022, 1'b0);
        wait_drain();

        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive(st_m[i][1:0], st_a[i], st_b[i], st_c[i], st_d[i], st_f[i], 1'b0);
                stream_done = 1'b1;
            end
            begin
                int k = 0;
                while (!stream_done) begin
                    out_ready = (k % 3 == 2);
                    k++;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        out_ready = 1'b0;
        drive(2'd0, 5, 3, 7, 2, 26, 1'b0);
        drive(2'd3, 7, 8, 0, 3, 45, 1'b0);
        drive(2'd1, 10, 20, 5, 9, 306, 1'b0);
        check("full_occupancy", 32'(occupancy), 32'd3);
        check("full_in_ready", 32'(in_ready), 32'd0);
        mode = 2'd2; a = 10'd11; b = 10'd22; c = 10'd33; d = 10'd44;
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        drive(2'd1, 10, 20, 5, 9, 306, 1'b0);
        drive(2'd3, 7, 8, 0, 3, 45, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_f", 32'(f), 32'd0);
        check("async_rst_occupancy", 32'(occupancy), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(2'd0, 5, 3, 7, 2, 26, 1'b0);
        check_latency("latency_after_reset");
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
